nubus_mem_arbiter: RTL and testbench
====================================

Name: nubus_mem_arbiter

Overview:
Shares the single card memory port (nubus_memory) between two requesters: the NuBus slave path and the local CPU port. NuBus slave accesses have priority so bus cycles are not stretched. A fairness counter prevents CPU starvation, and a CPU lock holds the memory for read-modify-write sequences. A watchdog terminates memory accesses that never return ready, so the NuBus cycle always ends.

Parameters:
SLAVE_BURST_MAX, 4, consecutive slave grants allowed while a local request is pending before local wins once (1..15).
TIMEOUT_CLOCKS, 64, cycles in a grant state without m_ready before forced error completion (2..255).

Ports:
mem_clk  in  1  clock, rising edge.
mem_reset  in  1  asynchronous reset, active-high.
s_valid  in  1  NuBus slave request, held until s_ready.
s_wstrb  in  4  slave byte strobes; 0 = read.
s_addr  in  32  slave address.
s_wdata  in  32  slave write data.
s_rdata  out  32  slave read data.
s_ready  out  1  slave completion pulse.
s_err  out  1  slave completion was a timeout; valid with s_ready.
l_valid  in  1  local CPU request, held until l_ready.
l_lock  in  1  local lock request, sampled with l_valid.
l_wstrb  in  4  local byte strobes.
l_addr  in  32  local address.
l_wdata  in  32  local write data.
l_rdata  out  32  local read data.
l_ready  out  1  local completion pulse.
l_err  out  1  local timeout flag; valid with l_ready.
m_valid  out  1  request to memory.
m_wstrb  out  4  to memory.
m_addr  out  32  to memory.
m_wdata  out  32  to memory.
m_rdata  in  32  from memory.
m_ready  in  1  memory completion.
locked  out  1  lock currently held by local.

Behaviour:
- Reset, asynchronous: state IDLE; m_valid, m_wstrb, m_addr, m_wdata = 0; locked = 0; fairness and timeout counters = 0. s_ready, l_ready, s_err and l_err read 0 while reset is asserted. Reset mid-transaction abandons the transaction with no ready pulse.
- States: IDLE, GNT_S, GNT_L, DONE.
- IDLE grant decision at each rising edge:
  - If locked, only l_valid is granted; s_valid waits.
  - Else if l_valid and fair_cnt == SLAVE_BURST_MAX, grant local.
  - Else s_valid grants slave, else l_valid grants local.
  - On grant, register the winner's wstrb/addr/wdata into m_*, set m_valid = 1, clear the timeout counter.
  - Request seen at edge N gives m_valid high after edge N, i.e. 1 cycle of arbitration latency.
- fair_cnt:
  - On a slave grant while l_valid is high, increment, saturating at SLAVE_BURST_MAX.
  - On any local grant, clear.
  - On a slave grant with l_valid low, clear.
- On a local grant: locked <= l_lock. locked clears in IDLE when l_valid is low, or l_valid is high with l_lock low.
- GNT_x:
  - x_ready = m_ready, combinational. x_rdata = m_rdata. x_err = 0.
  - On m_ready: m_valid <= 0, go to DONE.
  - Timeout counter increments each cycle. When it reaches TIMEOUT_CLOCKS-1 with m_ready low:
    - pulse x_ready = 1, x_err = 1, x_rdata = 32'hFFFFFFFF for that cycle;
    - m_valid <= 0; go to DONE.
- DONE: one mandatory dead cycle, no grant, so the requester can drop valid. Then IDLE. Back-to-back transactions therefore cost at least 1 (arbitrate) + memory latency + 1 (DONE) cycles.
- Non-granted requester: ready = 0, err = 0, rdata = 0.
- m_ready arriving outside GNT_x is ignored.
- m_* address/data stay stable for the whole grant.
- Simultaneous s_valid and l_valid with fair_cnt < SLAVE_BURST_MAX: slave wins.

Decomposition:
- Shared package nubus_inc: state encoding constants (ARB_IDLE, ARB_GNT_S, ARB_GNT_L, ARB_DONE) and TIMEOUT_RDATA = 32'hFFFFFFFF.
- One natural sub-module, nubus_arb_timer: loadable timeout counter with clear, enable and expire outputs.
- Grant logic and muxing stay in the top module.

Test Plan:
- Single slave write, wstrb=4'hF, addr=F0000000, data=87654321, memory wait 5: m_valid high the cycle after s_valid; s_ready pulses once when m_ready arrives; a later slave read returns 87654321 with s_err=0.
- Simultaneous s_valid and l_valid from idle: slave granted first (m_addr = slave addr); local granted after DONE; each ready pulses exactly once.
- Continuous slave requests with local pending, SLAVE_BURST_MAX=4: grant order S,S,S,S,L,S…; local completes within 5 grant slots.
- Local lock: l_lock=1 on a write to F0000010; slave request then pending; local issues a second request with lock=0. Slave is not granted until the second local transaction completes; locked drops in the following IDLE.
- Timeout: memory never asserts m_ready, TIMEOUT_CLOCKS=8. s_ready=1, s_err=1, s_rdata=FFFFFFFF on the 8th grant cycle; m_valid low next cycle; the next request is serviced normally.
- Reset asserted asynchronously mid-GNT_L: m_valid drops immediately, no l_ready pulse; after release a fresh slave read completes correctly.

Source files
------------

// File: rtl/nubus_inc.sv
// Shared definitions for the NuBus card memory arbiter: FSM state encoding
// and the read data returned on a watchdog-terminated access.
package nubus_inc;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_S = 2'd1,
    ARB_GNT_L = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/nubus_mem_arbiter_if.sv
// Bundle of the slave-path, local-CPU and memory-port signals around the arbiter.
interface nubus_mem_arbiter_if;
  import nubus_inc::*;

  // Handshake: a requester raises x_valid with stable wstrb/addr/wdata and holds
  // it until x_ready pulses for exactly one cycle; x_err/x_rdata are meaningful
  // only in that cycle. The memory port keeps m_* stable while m_valid is high
  // and completes with a single-cycle m_ready.
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        s_err;

  logic        l_valid;
  logic        l_lock;
  logic [3:0]  l_wstrb;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;
  logic        l_ready;
  logic        l_err;

  logic        m_valid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  logic        locked;
  arb_state_t  dbg_state;

  modport slave (
    input  s_valid, s_wstrb, s_addr, s_wdata,
    output s_rdata, s_ready, s_err,
    input  l_valid, l_lock, l_wstrb, l_addr, l_wdata,
    output l_rdata, l_ready, l_err,
    output m_valid, m_wstrb, m_addr, m_wdata,
    input  m_rdata, m_ready,
    output locked, dbg_state
  );

  modport master (
    output s_valid, s_wstrb, s_addr, s_wdata,
    input  s_rdata, s_ready, s_err,
    output l_valid, l_lock, l_wstrb, l_addr, l_wdata,
    input  l_rdata, l_ready, l_err,
    input  m_valid, m_wstrb, m_addr, m_wdata,
    output m_rdata, m_ready,
    input  locked, dbg_state
  );
endinterface

// File: rtl/nubus_arb_timer.sv
// Grant watchdog: counts enabled cycles from a clear and flags when the count
// reaches the loaded limit.
module nubus_arb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/nubus_mem_arbiter.sv
// Two-way arbiter for the card memory port: NuBus slave priority, local-CPU
// fairness after a slave burst, local lock for RMW, and a grant watchdog.
module nubus_mem_arbiter
  import nubus_inc::*;
#(
  parameter int SLAVE_BURST_MAX = 4,
  parameter int TIMEOUT_CLOCKS  = 64
) (
  input  logic                mem_clk,
  input  logic                mem_reset,
  nubus_mem_arbiter_if.slave  bus
);
  localparam logic [3:0] FAIR_MAX = 4'(SLAVE_BURST_MAX);
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CLOCKS - 1);

  arb_state_t  state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        locked_q, locked_d;
  logic [3:0]  fair_q, fair_d;

  logic in_s, in_l, in_gnt, grant_s, grant_l, expire, timed_out, finish;

  assign in_s   = (state_q == ARB_GNT_S);
  assign in_l   = (state_q == ARB_GNT_L);
  assign in_gnt = in_s || in_l;

  // While locked the slave is never considered; otherwise local wins only when
  // the slave is idle or has used up its burst allowance.
  assign grant_l = (state_q == ARB_IDLE) && bus.l_valid &&
                   (locked_q || (fair_q == FAIR_MAX) || !bus.s_valid);
  assign grant_s = (state_q == ARB_IDLE) && !locked_q && bus.s_valid && !grant_l;

  nubus_arb_timer #(.W(8)) u_timer (
    .clk    (mem_clk),
    .rst    (mem_reset),
    .clr    (grant_s || grant_l),
    .en     (in_gnt),
    .limit  (TO_LIMIT),
    .expire (expire)
  );

  assign timed_out = expire && !bus.m_ready;
  assign finish    = in_gnt && (bus.m_ready || expire);

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_wstrb_d = m_wstrb_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    locked_d  = locked_q;
    fair_d    = fair_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_s) begin
          state_d   = ARB_GNT_S;
          m_valid_d = 1'b1;
          m_wstrb_d = bus.s_wstrb;
          m_addr_d  = bus.s_addr;
          m_wdata_d = bus.s_wdata;
          if (!bus.l_valid)           fair_d = '0;
          else if (fair_q != FAIR_MAX) fair_d = fair_q + 4'd1;
        end else if (grant_l) begin
          state_d   = ARB_GNT_L;
          m_valid_d = 1'b1;
          m_wstrb_d = bus.l_wstrb;
          m_addr_d  = bus.l_addr;
          m_wdata_d = bus.l_wdata;
          fair_d    = '0;
          locked_d  = bus.l_lock;
        end else if (!bus.l_valid) begin
          locked_d = 1'b0;
        end
      end
      ARB_GNT_S, ARB_GNT_L: begin
        if (finish) begin
          m_valid_d = 1'b0;
          state_d   = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q   <= ARB_IDLE;
      m_valid_q <= 1'b0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      locked_q  <= 1'b0;
      fair_q    <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_wstrb_q <= m_wstrb_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      locked_q  <= locked_d;
      fair_q    <= fair_d;
    end
  end

  // Completion toward the granted requester follows m_ready combinationally;
  // the other requester sees all zeros.
  assign bus.s_ready   = in_s && (bus.m_ready || expire);
  assign bus.s_err     = in_s && timed_out;
  assign bus.s_rdata   = !in_s ? 32'h0 : (timed_out ? TIMEOUT_RDATA : bus.m_rdata);
  assign bus.l_ready   = in_l && (bus.m_ready || expire);
  assign bus.l_err     = in_l && timed_out;
  assign bus.l_rdata   = !in_l ? 32'h0 : (timed_out ? TIMEOUT_RDATA : bus.m_rdata);
  assign bus.m_valid   = m_valid_q;
  assign bus.m_wstrb   = m_wstrb_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.locked    = locked_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Directed bench for nubus_mem_arbiter: drivers per requester, a memory model,
// and a negedge monitor that scores grants and completions against queues.
module tb_nubus_mem_arbiter;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  nubus_mem_arbiter_if bus ();

  nubus_mem_arbiter #(.SLAVE_BURST_MAX(4), .TIMEOUT_CLOCKS(8)) dut (
    .mem_clk   (clk),
    .mem_reset (rst),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_s_q[$];   // {err, rdata}
  logic [32:0] exp_l_q[$];
  logic [67:0] exp_g_q[$];   // {addr, wstrb, wdata}
  logic        mv_prev = 1'b0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int          mem_wait = 5;
  bit          mem_hang = 0;
  int          mem_cnt  = 0;

  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.m_valid) begin
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        mem_cnt     = 0;
      end else if (!bus.m_ready) begin
        mem_cnt++;
        if (!mem_hang && mem_cnt >= mem_wait) begin
          logic [31:0] word;
          word = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
          if (bus.m_wstrb == 4'h0) begin
            bus.m_rdata = word;
          end else begin
            for (int i = 0; i < 4; i++)
              if (bus.m_wstrb[i]) word[8*i +: 8] = bus.m_wdata[8*i +: 8];
            mem[bus.m_addr] = word;
            bus.m_rdata = '0;
          end
          bus.m_ready = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      mv_prev = 1'b0;
    end else begin
      if (bus.m_valid && !mv_prev) begin
        if (exp_g_q.size() == 0) chk("grant_unexpected", {bus.m_addr, bus.m_wstrb, bus.m_wdata}, 68'h0);
        else chk("grant", {bus.m_addr, bus.m_wstrb, bus.m_wdata}, exp_g_q.pop_front());
      end
      mv_prev = bus.m_valid;
      if (bus.s_ready && bus.l_ready) chk("both_ready", 68'd1, 68'd0);
      if (bus.s_ready) begin
        if (exp_s_q.size() == 0) chk("s_ready_extra", {bus.s_err, bus.s_rdata}, 68'h0);
        else chk("s_resp", {bus.s_err, bus.s_rdata}, exp_s_q.pop_front());
      end
      if (bus.l_ready) begin
        if (exp_l_q.size() == 0) chk("l_ready_extra", {bus.l_err, bus.l_rdata}, 68'h0);
        else chk("l_resp", {bus.l_err, bus.l_rdata}, exp_l_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic slave_txn(input logic [3:0] st, input logic [31:0] a, input logic [31:0] d,
                           input logic e_err, input logic [31:0] e_rd, output int lat);
    bit got = 0;
    exp_s_q.push_back({e_err, e_rd});
    bus.s_wstrb = st; bus.s_addr = a; bus.s_wdata = d; bus.s_valid = 1'b1;
    lat = 0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.s_ready) got = 1;
    end
    if (!got) chk("s_wait_timeout", 68'd0, 68'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0; bus.s_wstrb = '0; bus.s_addr = '0; bus.s_wdata = '0;
  endtask

  task automatic local_txn(input logic lk, input logic [3:0] st, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e_rd);
    bit got = 0;
    int n = 0;
    exp_l_q.push_back({1'b0, e_rd});
    bus.l_lock = lk; bus.l_wstrb = st; bus.l_addr = a; bus.l_wdata = d; bus.l_valid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.l_ready) got = 1;
    end
    if (!got) chk("l_wait_timeout", 68'd0, 68'd1);
    @(posedge clk);
    #1;
    bus.l_valid = 1'b0; bus.l_lock = 1'b0; bus.l_wstrb = '0; bus.l_addr = '0; bus.l_wdata = '0;
  endtask

  task automatic wait_mvalid(input string nm);
    int n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.m_valid) chk(nm, 68'd0, 68'd1);
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] g(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    return {a, st, d};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b1;
    bus.s_valid = 0; bus.s_wstrb = 0; bus.s_addr = 0; bus.s_wdata = 0;
    bus.l_valid = 0; bus.l_lock = 0; bus.l_wstrb = 0; bus.l_addr = 0; bus.l_wdata = 0;
    #3;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_ready", {bus.s_ready, bus.l_ready, bus.s_err, bus.l_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single slave write then read back
    exp_g_q.push_back(g(32'hF000_0000, 4'hF, 32'h8765_4321));
    fork
      slave_txn(4'hF, 32'hF000_0000, 32'h8765_4321, 1'b0, 32'h0, lat);
      begin
        @(negedge clk); chk("mv_before_grant", bus.m_valid, 0);
        @(negedge clk); chk("mv_after_grant", bus.m_valid, 1);
      end
    join
    chk("write_latency", 68'(lat), 68'd6);
    exp_g_q.push_back(g(32'hF000_0000, 4'h0, 32'h0));
    slave_txn(4'h0, 32'hF000_0000, 32'h0, 1'b0, 32'h8765_4321, lat);
    idle_gap();

    // Simultaneous request: slave first, then local
    exp_g_q.push_back(g(32'hF000_0040, 4'hF, 32'h1));
    exp_g_q.push_back(g(32'hF000_0044, 4'hF, 32'h2));
    fork
      slave_txn(4'hF, 32'hF000_0040, 32'h1, 1'b0, 32'h0, lat);
      local_txn(1'b0, 4'hF, 32'hF000_0044, 32'h2, 32'h0);
    join
    idle_gap();

    // Fairness: S,S,S,S,L,S,S with local held pending
    for (int i = 0; i < 4; i++) exp_g_q.push_back(g(32'hF000_0100 + 32'(4*i), 4'hF, 32'(i)));
    exp_g_q.push_back(g(32'hF000_0200, 4'hF, 32'h1111_2222));
    for (int i = 4; i < 6; i++) exp_g_q.push_back(g(32'hF000_0100 + 32'(4*i), 4'hF, 32'(i)));
    fork
      for (int i = 0; i < 6; i++) begin
        int l2;
        slave_txn(4'hF, 32'hF000_0100 + 32'(4*i), 32'(i), 1'b0, 32'h0, l2);
      end
      local_txn(1'b0, 4'hF, 32'hF000_0200, 32'h1111_2222, 32'h0);
    join
    idle_gap();

    // Lock: two local accesses keep the slave out; partial-strobe slave write
    exp_g_q.push_back(g(32'hF000_0010, 4'hF, 32'hA5A5_A5A5));
    exp_g_q.push_back(g(32'hF000_0010, 4'h0, 32'h0));
    exp_g_q.push_back(g(32'hF000_0020, 4'h3, 32'h1234_5678));
    fork
      begin
        local_txn(1'b1, 4'hF, 32'hF000_0010, 32'hA5A5_A5A5, 32'h0);
        local_txn(1'b0, 4'h0, 32'hF000_0010, 32'h0, 32'hA5A5_A5A5);
      end
      begin
        @(negedge clk);
        wait_mvalid("lock_grant_wait");
        chk("locked_set", bus.locked, 1);
        slave_txn(4'h3, 32'hF000_0020, 32'h1234_5678, 1'b0, 32'h0, lat);
      end
    join
    chk("locked_clear", bus.locked, 0);
    exp_g_q.push_back(g(32'hF000_0020, 4'h0, 32'h0));
    slave_txn(4'h0, 32'hF000_0020, 32'h0, 1'b0, 32'h0000_5678, lat);
    idle_gap();

    // Watchdog: memory never answers
    mem_hang = 1;
    exp_g_q.push_back(g(32'hF000_0030, 4'h0, 32'h0));
    slave_txn(4'h0, 32'hF000_0030, 32'h0, 1'b1, 32'hFFFF_FFFF, lat);
    chk("timeout_latency", 68'(lat), 68'd9);
    chk("timeout_mv_low", bus.m_valid, 0);
    mem_hang = 0;
    exp_g_q.push_back(g(32'hF000_0000, 4'h0, 32'h0));
    slave_txn(4'h0, 32'hF000_0000, 32'h0, 1'b0, 32'h8765_4321, lat);
    idle_gap();

    // Asynchronous reset in the middle of a local grant
    mem_hang = 1;
    exp_g_q.push_back(g(32'hF000_0050, 4'hF, 32'h0000_CAFE));
    bus.l_lock = 1; bus.l_wstrb = 4'hF; bus.l_addr = 32'hF000_0050; bus.l_wdata = 32'h0000_CAFE;
    bus.l_valid = 1;
    @(negedge clk);
    wait_mvalid("rst_grant_wait");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_m_valid", bus.m_valid, 0);
    chk("rst_mid_l_ready", {bus.l_ready, bus.l_err}, 0);
    chk("rst_mid_locked", bus.locked, 0);
    bus.l_valid = 0; bus.l_lock = 0; bus.l_wstrb = 0; bus.l_addr = 0; bus.l_wdata = 0;
    mem_hang = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_g_q.push_back(g(32'hF000_0000, 4'h0, 32'h0));
    slave_txn(4'h0, 32'hF000_0000, 32'h0, 1'b0, 32'h8765_4321, lat);
    idle_gap();

    chk("s_queue_empty", 68'(exp_s_q.size()), 68'd0);
    chk("l_queue_empty", 68'(exp_l_q.size()), 68'd0);
    chk("g_queue_empty", 68'(exp_g_q.size()), 68'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
